// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Final (memory/writeback) pipeline stage of the 16-bit WISC CPU.
// Accepts a retiring instruction from the EX/MEM boundary, waits for a
// variable-latency data-memory return when the instruction is a load,
// selects the writeback value and drives the register-file write port.
// While a load is outstanding the stage back-pressures upstream. If memory
// never answers within MEM_TIMEOUT cycles the load is abandoned and a
// sticky error is raised.
//
// Handshake: an instruction is captured on a rising edge exactly when
// ex_valid=1, flush=0 and wb_stall=0 in that cycle. Upstream must hold the
// same instruction on its ex_* inputs for as long as wb_stall=1.
// mem_rvalid is a one-cycle qualifier for mem_rdata. It is only honoured
// while a load is held.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   ex_valid                   upstream presents a retiring instruction
//   ex_dst_reg[3:0]            destination register ID
//   ex_reg_write               instruction writes a register
//   ex_mem_to_reg              instruction is a load
//   ex_pc_to_reg               instruction writes PC+2 (ignored for loads)
//   ex_alu_result[15:0]        ALU result
//   ex_pc_next[15:0]           PC+2 of the instruction
//   flush                      squash the instruction presented this cycle
//   mem_rdata[15:0]            load data
//   mem_rvalid                 mem_rdata valid this cycle
//   wb_stall                   upstream must hold its instruction
//   DstReg[3:0]                register-file destination ID
//   WriteReg                   register-file write enable
//   DstData[15:0]              register-file write data
//   mem_err                    sticky load-timeout error
//   o_dbg_state[1:0]           current FSM state (0=IDLE 1=COMMIT 2=WAIT_MEM)
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_dst_reg,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_pc_to_reg,
    input  logic [15:0] ex_alu_result,
    input  logic [15:0] ex_pc_next,
    input  logic        flush,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        wb_stall,
    output logic [3:0]  DstReg,
    output logic        WriteReg,
    output logic [15:0] DstData,
    output logic        mem_err,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_WAIT_MEM = 2'd2
    } state_t;

    // Counter value during the last WAIT_MEM cycle before abandoning the load.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_next;

    logic [3:0]        r_dst;
    logic              r_reg_write;
    logic              r_pc_to_reg;
    logic [15:0]       r_alu_result;
    logic [15:0]       r_pc_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [3:0]        r_last_dst;
    logic [15:0]       r_last_data;

    logic              w_in_wait;
    logic              w_stall;
    logic              w_capture;
    logic              w_fire;
    logic              w_write;
    logic              w_timeout;
    logic [15:0]       w_result;

    // -----------------------------------------------------------------------
    // Datapath / control decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_in_wait = (r_state == S_WAIT_MEM);
        w_stall   = w_in_wait & ~mem_rvalid;
        w_capture = ex_valid & ~flush & ~w_stall;
        // A held instruction retires this cycle: non-loads always, loads only
        // when the data arrives.
        w_fire    = (r_state == S_COMMIT) | (w_in_wait & mem_rvalid);
        w_write   = w_fire & r_reg_write & (r_dst != 4'd0);
        // Data arriving on the last allowed cycle wins over the timeout.
        w_timeout = w_in_wait & ~mem_rvalid & (r_cnt == C_CNT_LAST);
        // Load data is passed straight through so the write lands in the
        // same cycle mem_rvalid arrives.
        w_result  = w_in_wait ? mem_rdata
                              : (r_pc_to_reg ? r_pc_next : r_alu_result);
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_COMMIT: begin
                if (w_capture)
                    w_state_next = ex_mem_to_reg ? S_WAIT_MEM : S_COMMIT;
                else
                    w_state_next = S_IDLE;
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    if (w_capture)
                        w_state_next = ex_mem_to_reg ? S_WAIT_MEM : S_COMMIT;
                    else
                        w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // -----------------------------------------------------------------------
    // Captured instruction fields
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dst        <= 4'd0;
            r_reg_write  <= 1'b0;
            r_pc_to_reg  <= 1'b0;
            r_alu_result <= 16'd0;
            r_pc_next    <= 16'd0;
        end else if (w_capture) begin
            r_dst        <= ex_dst_reg;
            r_reg_write  <= ex_reg_write;
            r_pc_to_reg  <= ex_pc_to_reg;
            r_alu_result <= ex_alu_result;
            r_pc_next    <= ex_pc_next;
        end
    end

    // -----------------------------------------------------------------------
    // Timeout counter and sticky error
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            // Counts only while still waiting; clears on data or timeout.
            if (w_stall && !w_timeout)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Last issued write, so DstReg/DstData hold while WriteReg=0
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_dst  <= 4'd0;
            r_last_data <= 16'd0;
        end else if (w_write) begin
            r_last_dst  <= r_dst;
            r_last_data <= w_result;
        end
    end

    assign wb_stall    = w_stall;
    assign WriteReg    = w_write;
    assign DstReg      = w_write ? r_dst    : r_last_dst;
    assign DstData     = w_write ? w_result : r_last_data;
    assign mem_err     = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int MEM_TIMEOUT = 15;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        ex_valid = 1'b0;
    logic [3:0]  ex_dst_reg = 4'd0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_to_reg = 1'b0;
    logic        ex_pc_to_reg = 1'b0;
    logic [15:0] ex_alu_result = 16'd0;
    logic [15:0] ex_pc_next = 16'd0;
    logic        flush = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_rvalid = 1'b0;
    logic        wb_stall;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic        mem_err;
    logic [1:0]  dbg_state;

    mem_wb_stage #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_dst_reg    (ex_dst_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_pc_to_reg  (ex_pc_to_reg),
        .ex_alu_result (ex_alu_result),
        .ex_pc_next    (ex_pc_next),
        .flush         (flush),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .wb_stall      (wb_stall),
        .DstReg        (DstReg),
        .WriteReg      (WriteReg),
        .DstData       (DstData),
        .mem_err       (mem_err),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];   // expected write data, in retirement order

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One "held" instruction slot; a load waits until data shows up or until
    // it has spent MEM_TIMEOUT cycles waiting.
    bit          m_held, m_load, m_rw, m_pcr, m_err;
    logic [3:0]  m_dst, m_last_dst;
    logic [15:0] m_alu, m_pcn, m_last_data;
    int          m_waited;

    task automatic model_reset();
        m_held = 0; m_load = 0; m_rw = 0; m_pcr = 0; m_err = 0;
        m_dst = 0; m_last_dst = 0; m_alu = 0; m_pcn = 0; m_last_data = 0;
        m_waited = 0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Entered one time unit after a rising edge; drives one cycle, checks the
    // outputs against the model mid-cycle, then advances the model across
    // the next edge.
    task automatic run_cycle(input bit ev, input logic [3:0] dst, input bit rw,
                             input bit m2r, input bit pcr, input logic [15:0] alu,
                             input logic [15:0] pcn, input bit fl,
                             input bit rv, input logic [15:0] rd);
        bit          e_stall, e_wr, cap, waiting;
        logic [15:0] e_data;
        logic [3:0]  e_dst;
        ex_valid = ev; ex_dst_reg = dst; ex_reg_write = rw; ex_mem_to_reg = m2r;
        ex_pc_to_reg = pcr; ex_alu_result = alu; ex_pc_next = pcn; flush = fl;
        mem_rvalid = rv; mem_rdata = rd;
        #1;
        waiting = m_held && m_load && !rv;
        e_stall = waiting;
        e_wr    = m_held && (!m_load || rv) && m_rw && (m_dst != 0);
        e_data  = m_load ? rd : (m_pcr ? m_pcn : m_alu);
        e_dst   = m_dst;
        if (!e_wr) begin
            e_data = m_last_data;
            e_dst  = m_last_dst;
        end
        check_eq("wb_stall", {31'd0, wb_stall}, {31'd0, e_stall});
        check_eq("WriteReg", {31'd0, WriteReg}, {31'd0, e_wr});
        check_eq("DstReg",   {28'd0, DstReg},   {28'd0, e_dst});
        check_eq("DstData",  {16'd0, DstData},  {16'd0, e_data});
        check_eq("mem_err",  {31'd0, mem_err},  {31'd0, m_err});
        if (WriteReg && exp_q.size() > 0) begin
            check_eq("wr_order", {16'd0, DstData}, {16'd0, exp_q.pop_front()});
        end
        // advance model across the edge
        cap = ev && !fl && !e_stall;
        if (e_wr) begin
            m_last_data = e_data;
            m_last_dst  = e_dst;
        end
        if (waiting && (m_waited + 1 == MEM_TIMEOUT)) begin
            m_err  = 1;
            m_held = 0;
            m_waited = 0;
        end else if (waiting) begin
            m_waited++;
        end else begin
            m_held = cap; m_load = m2r; m_dst = dst; m_rw = rw; m_pcr = pcr;
            m_alu = alu; m_pcn = pcn; m_waited = 0;
            // non-load data is known at capture; queue it for the order check
            if (cap && !m2r && rw && dst != 0) exp_q.push_back(pcr ? pcn : alu);
            if (cap && m2r) exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input bit rv, input logic [15:0] rd);
        run_cycle(0, 4'd0, 0, 0, 0, 16'd0, 16'd0, 0, rv, rd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1;
        // asynchronous reset: outputs clear before any clock edge
        check_eq("rst_WriteReg", {31'd0, WriteReg}, 32'd0);
        check_eq("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
        check_eq("rst_DstReg",   {28'd0, DstReg},   32'd0);
        check_eq("rst_DstData",  {16'd0, DstData},  32'd0);
        check_eq("rst_mem_err",  {31'd0, mem_err},  32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        // ALU back-to-back
        run_cycle(1, 4'd3, 1, 0, 0, 16'h1234, 16'h0010, 0, 0, 0);
        run_cycle(1, 4'd5, 1, 0, 0, 16'hBEEF, 16'h0012, 0, 0, 0);
        idle_cycle(0, 0);
        idle_cycle(0, 0);

        // PCS, then a write to R0
        run_cycle(1, 4'd7, 1, 0, 1, 16'h9999, 16'h0042, 0, 0, 0);
        run_cycle(1, 4'd0, 1, 0, 0, 16'h5555, 16'h0044, 0, 0, 0);
        idle_cycle(0, 0);

        // load with data after 3 waiting cycles; next instr held meanwhile
        run_cycle(1, 4'd2, 1, 1, 0, 16'h0000, 16'h0050, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            run_cycle(1, 4'd4, 1, 0, 0, 16'h7777, 16'h0052, 0, 0, 16'hDEAD);
        run_cycle(1, 4'd4, 1, 0, 0, 16'h7777, 16'h0052, 0, 1, 16'hA5A5);
        idle_cycle(0, 0);

        // timeout: no data, error sticks, late data ignored
        run_cycle(1, 4'd6, 1, 1, 0, 16'h0000, 16'h0060, 0, 0, 0);
        for (int i = 0; i < MEM_TIMEOUT + 2; i++) idle_cycle(0, 16'h0BAD);
        idle_cycle(1, 16'h1111);
        idle_cycle(0, 0);
        check_eq("err_sticky", {31'd0, mem_err}, 32'd1);

        // flush discards the presented instruction
        run_cycle(1, 4'd9, 1, 0, 0, 16'hF00D, 16'h0070, 1, 0, 0);
        idle_cycle(0, 0);

        // reset during WAIT_MEM
        run_cycle(1, 4'd8, 1, 1, 0, 16'h0000, 16'h0080, 0, 0, 0);
        idle_cycle(0, 0);
        #3;
        rst = 1;
        #1;
        check_eq("midrst_WriteReg", {31'd0, WriteReg}, 32'd0);
        check_eq("midrst_wb_stall", {31'd0, wb_stall}, 32'd0);
        check_eq("midrst_DstReg",   {28'd0, DstReg},   32'd0);
        check_eq("midrst_DstData",  {16'd0, DstData},  32'd0);
        check_eq("midrst_mem_err",  {31'd0, mem_err},  32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        idle_cycle(1, 16'hFFFF);
        idle_cycle(0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            run_cycle($urandom_range(0, 9) < 7,
                      4'($urandom_range(0, 15)),
                      $urandom_range(0, 7) != 0,
                      $urandom_range(0, 9) < 3,
                      $urandom_range(0, 3) == 0,
                      16'($urandom_range(0, 65535)),
                      16'($urandom_range(0, 65535)),
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) < 3,
                      16'($urandom_range(0, 65535)));
        end
        idle_cycle(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
